// File: rtl/snake_frame_renderer_if.sv
// Game-state snapshot inputs and character beat stream of the snake frame renderer.
// slave = renderer side, master = game core plus character sink side.
interface snake_frame_renderer_if #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int COORD_W = 4,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
);
    logic                         frame_start;
    logic [MAX_LEN*COORD_W-1:0]   snake_x;
    logic [MAX_LEN*COORD_W-1:0]   snake_y;
    logic [LEN_W-1:0]             snake_len;
    logic [COORD_W-1:0]           apple_x;
    logic [COORD_W-1:0]           apple_y;
    logic                         apple_en;
    logic [GRID_W*GRID_H-1:0]     board;
    logic                         out_valid;
    logic                         out_ready;
    logic [7:0]                   out_char;
    logic [COORD_W-1:0]           out_col;
    logic [COORD_W-1:0]           out_row;
    logic                         out_eol;
    logic                         out_eof;
    logic                         busy;
    logic [15:0]                  frame_count;
    logic                         frame_drop;

    modport master (
        output frame_start, snake_x, snake_y, snake_len, apple_x, apple_y, apple_en, board,
        output out_ready,
        input  out_valid, out_char, out_col, out_row, out_eol, out_eof,
        input  busy, frame_count, frame_drop
    );

    modport slave (
        input  frame_start, snake_x, snake_y, snake_len, apple_x, apple_y, apple_en, board,
        input  out_ready,
        output out_valid, out_char, out_col, out_row, out_eol, out_eof,
        output busy, frame_count, frame_drop
    );
endinterface

// File: rtl/snake_frame_renderer.sv
// Snapshots snake/apple/walls on frame_start and raster-scans one ASCII char per accepted beat.
// First beat 1 cycle after frame_start; beat registers hold while out_ready is low.
module snake_frame_renderer #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int COORD_W = 4,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input logic                  clk,
    input logic                  rst,
    snake_frame_renderer_if.slave bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(GRID_H - 1);

    state_t                       state_q;
    logic                         valid_q, busy_q, eol_q, eof_q, drop_q;
    logic [7:0]                   char_q;
    logic [COORD_W-1:0]           col_q, row_q;
    logic [15:0]                  count_q;
    logic [MAX_LEN*COORD_W-1:0]   snap_x_q, snap_y_q;
    logic [LEN_W-1:0]             snap_len_q;
    logic [COORD_W-1:0]           snap_ax_q, snap_ay_q;
    logic                         snap_aen_q;
    logic [GRID_W*GRID_H-1:0]     snap_board_q;

    logic [COORD_W-1:0]           col_d, row_d;
    logic                         eol_d, eof_d, xfer;
    logic [7:0]                   char_scan_d, char_first_d;

    function automatic logic [7:0] cell_char(
        input logic [COORD_W-1:0]         cx,
        input logic [COORD_W-1:0]         cy,
        input logic [MAX_LEN*COORD_W-1:0] sx,
        input logic [MAX_LEN*COORD_W-1:0] sy,
        input logic [LEN_W-1:0]           len,
        input logic [COORD_W-1:0]         ax,
        input logic [COORD_W-1:0]         ay,
        input logic                       aen,
        input logic [GRID_W*GRID_H-1:0]   brd
    );
        logic [GRID_W*GRID_H-1:0] wall_sh;
        logic                     head, body;
        int                       eff;
        eff     = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        wall_sh = brd >> (int'(cy) * GRID_W + int'(cx));
        head    = (eff >= 1) && (sx[0 +: COORD_W] == cx) && (sy[0 +: COORD_W] == cy);
        body    = 1'b0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (k < eff && sx[k*COORD_W +: COORD_W] == cx && sy[k*COORD_W +: COORD_W] == cy)
                body = 1'b1;
        end
        if (wall_sh[0])                        return 8'h78;
        else if (head)                         return 8'h40;
        else if (body)                         return 8'h23;
        else if (aen && ax == cx && ay == cy)  return 8'h6F;
        else                                   return 8'h2E;
    endfunction

    // Next cursor and its character are computed ahead so a new beat is ready every cycle.
    always_comb begin
        col_d        = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        row_d        = (col_q == LAST_COL) ? row_q + 1'b1 : row_q;
        eol_d        = (col_d == LAST_COL);
        eof_d        = (col_d == LAST_COL) && (row_d == LAST_ROW);
        xfer         = valid_q && bus.out_ready;
        char_scan_d  = cell_char(col_d, row_d, snap_x_q, snap_y_q, snap_len_q,
                                 snap_ax_q, snap_ay_q, snap_aen_q, snap_board_q);
        char_first_d = cell_char('0, '0, bus.snake_x, bus.snake_y, bus.snake_len,
                                 bus.apple_x, bus.apple_y, bus.apple_en, bus.board);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            char_q       <= 8'h00;
            col_q        <= '0;
            row_q        <= '0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            count_q      <= '0;
            drop_q       <= 1'b0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_len_q   <= '0;
            snap_ax_q    <= '0;
            snap_ay_q    <= '0;
            snap_aen_q   <= 1'b0;
            snap_board_q <= '0;
        end else begin
            drop_q <= bus.frame_start && (state_q == SCAN);
            case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        snap_x_q     <= bus.snake_x;
                        snap_y_q     <= bus.snake_y;
                        snap_len_q   <= bus.snake_len;
                        snap_ax_q    <= bus.apple_x;
                        snap_ay_q    <= bus.apple_y;
                        snap_aen_q   <= bus.apple_en;
                        snap_board_q <= bus.board;
                        state_q      <= SCAN;
                        valid_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        col_q        <= '0;
                        row_q        <= '0;
                        char_q       <= char_first_d;
                        eol_q        <= 1'b0;
                        eof_q        <= 1'b0;
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        if (eof_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            eol_q   <= 1'b0;
                            eof_q   <= 1'b0;
                            count_q <= count_q + 16'd1;
                        end else begin
                            col_q  <= col_d;
                            row_q  <= row_d;
                            char_q <= char_scan_d;
                            eol_q  <= eol_d;
                            eof_q  <= eof_d;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_char    = char_q;
    assign bus.out_col     = col_q;
    assign bus.out_row     = row_q;
    assign bus.out_eol     = eol_q;
    assign bus.out_eof     = eof_q;
    assign bus.busy        = busy_q;
    assign bus.frame_count = count_q;
    assign bus.frame_drop  = drop_q;
endmodule
